// File: rtl/design_select_seq.sv
// Sequencer for the top_design_mux selection pair. Every design change parks the mux on
// an unused ID for a guard interval first, and the block reports the last ID it committed.
module design_select_seq #(
    parameter logic [3:0]  PARK_ID      = 4'd14,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned PULSE_W      = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_stb,
    input  logic [3:0] req_id,
    output logic       sel_clk,
    output logic [3:0] sel_id,
    output logic       busy,
    output logic [3:0] cur_id,
    output logic       cur_valid,
    output logic       overrun
);

    typedef enum logic [3:0] {
        StIdle,
        StPSet,
        StPHi,
        StPHld,
        StGuard,
        StTSet,
        StTHi,
        StTHld,
        StAck
    } state_e;

    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GuardLoad = CNT_W'(GUARD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        tgt_q, tgt_d;
    logic              s1_q, s2_q, s3_q;
    logic              sel_clk_q, sel_clk_d;
    logic [3:0]        sel_id_q, sel_id_d;
    logic              busy_q, busy_d;
    logic [3:0]        cur_id_q, cur_id_d;
    logic              cur_valid_q, cur_valid_d;
    logic              overrun_q, overrun_d;
    logic              start;

    assign start = s2_q & ~s3_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        cur_id_d    = cur_id_q;
        cur_valid_d = cur_valid_q;
        overrun_d   = overrun_q | (start & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tgt_d = req_id;
                    if (req_id == cur_id_q && cur_valid_q) begin
                        state_d = StAck;
                    end else if (req_id == PARK_ID) begin
                        state_d = StTSet;
                    end else begin
                        state_d = StPSet;
                    end
                end
            end
            StPSet:  state_d = StPHi;
            StPHi:   if (cnt_q == '0) state_d = StPHld;
            StPHld:  state_d = StGuard;
            StGuard: if (cnt_q == '0) state_d = StTSet;
            StTSet:  state_d = StTHi;
            StTHi:   if (cnt_q == '0) state_d = StTHld;
            StTHld:  state_d = StAck;
            StAck: begin
                cur_id_d    = tgt_q;
                cur_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Counter reloads on every state entry and saturates at zero.
        if (state_d != state_q) begin
            unique case (state_d)
                StPHi, StTHi: cnt_d = PulseLoad;
                StGuard:      cnt_d = GuardLoad;
                default:      cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Outputs are registered copies of the next state's decode.
        sel_clk_d = (state_d == StPHi) || (state_d == StTHi);
        busy_d    = (state_d != StIdle);
        sel_id_d  = sel_id_q;
        if (state_d == StPSet) sel_id_d = PARK_ID;
        if (state_d == StTSet) sel_id_d = tgt_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tgt_q       <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            sel_clk_q   <= 1'b0;
            sel_id_q    <= PARK_ID;
            busy_q      <= 1'b0;
            cur_id_q    <= '0;
            cur_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            s1_q        <= req_stb;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            sel_clk_q   <= sel_clk_d;
            sel_id_q    <= sel_id_d;
            busy_q      <= busy_d;
            cur_id_q    <= cur_id_d;
            cur_valid_q <= cur_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sel_clk   = sel_clk_q;
    assign sel_id    = sel_id_q;
    assign busy      = busy_q;
    assign cur_id    = cur_id_q;
    assign cur_valid = cur_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_design_select_seq.sv
// Directed bench for design_select_seq; sel_clk/sel_id ordering is checked on every cycle.
module tb_design_select_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_stb;
    logic [3:0] req_id;
    logic       sel_clk;
    logic [3:0] sel_id;
    logic       busy;
    logic [3:0] cur_id;
    logic       cur_valid;
    logic       overrun;

    design_select_seq dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_stb   (req_stb),
        .req_id    (req_id),
        .sel_clk   (sel_clk),
        .sel_id    (sel_id),
        .busy      (busy),
        .cur_id    (cur_id),
        .cur_valid (cur_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc = 0;
    int         rise_cnt = 0;
    int         last_rise = 0;
    int         last_fall = 0;
    int         last_width = 0;
    int         fall_to_rise = 0;
    logic       prev_clk = 1'b0;
    logic [3:0] prev_id = 4'd14;
    logic       prev_rise = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge and check selection ordering.
    task automatic step();
        logic rise;
        @(negedge clk);
        cyc++;
        rise = sel_clk && !prev_clk;
        if (prev_rise) check("sel_id_after_rise", {28'd0, sel_id}, {28'd0, prev_id});
        if (rise) begin
            check("sel_id_before_rise", {28'd0, sel_id}, {28'd0, prev_id});
            rise_cnt++;
            fall_to_rise = cyc - last_fall;
            last_rise    = cyc;
        end
        if (!sel_clk && prev_clk) begin
            last_width = cyc - last_rise;
            last_fall  = cyc;
        end
        if (sel_id != prev_id && sel_id != 4'd14) begin
            check("no_direct_switch", {28'd0, prev_id}, 32'd14);
        end
        prev_rise = rise;
        prev_clk  = sel_clk;
        prev_id   = sel_id;
    endtask

    // Issue one request; optionally raise a second req_stb once busy has lasted second_at.
    task automatic run_req(input logic [3:0] id, input int second_at, input logic [3:0] id2,
                           output int busy_len, output int rises);
        bit seen = 0;
        bit done = 0;
        int sec_i = -1;
        int r0 = rise_cnt;
        busy_len = 0;
        req_id  = id;
        req_stb = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (i == 2) req_stb = 1'b0;
            if (busy) begin
                busy_len++;
                seen = 1;
            end
            if (second_at != 0 && sec_i < 0 && busy_len == second_at) begin
                req_stb = 1'b1;
                req_id  = id2;
                sec_i   = i;
            end
            if (sec_i >= 0 && i == sec_i + 3) req_stb = 1'b0;
            if (seen && !busy) begin
                done = 1;
                break;
            end
        end
        check("request_completes", {31'd0, done}, 32'd1);
        req_stb = 1'b0;
        step();
        step();
        rises = rise_cnt - r0;
    endtask

    initial begin
        int blen;
        int nr;
        int r0;
        rst     = 1'b1;
        req_stb = 1'b0;
        req_id  = 4'd0;
        step();
        step();
        step();
        check("rst_sel_clk", {31'd0, sel_clk}, 32'd0);
        check("rst_sel_id", {28'd0, sel_id}, 32'd14);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cur_id", {28'd0, cur_id}, 32'd0);
        check("rst_cur_valid", {31'd0, cur_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step();
        step();

        // Full path to id 0 from reset
        run_req(4'd0, 0, 4'd0, blen, nr);
        check("t1_busy_len", blen, 32'd25);
        check("t1_rises", nr, 32'd2);
        check("t1_pulse_width", last_width, 32'd2);
        check("t1_fall_to_rise", fall_to_rise, 32'd18);
        check("t1_sel_id", {28'd0, sel_id}, 32'd0);
        check("t1_cur_id", {28'd0, cur_id}, 32'd0);
        check("t1_cur_valid", {31'd0, cur_valid}, 32'd1);

        // Same ID again: ACK only
        run_req(4'd0, 0, 4'd0, blen, nr);
        check("t2_busy_len", blen, 32'd1);
        check("t2_rises", nr, 32'd0);
        check("t2_cur_id", {28'd0, cur_id}, 32'd0);

        // Move to 3, then to the park ID directly
        run_req(4'd3, 0, 4'd0, blen, nr);
        check("t3a_busy_len", blen, 32'd25);
        check("t3a_cur_id", {28'd0, cur_id}, 32'd3);
        check("t3a_sel_id", {28'd0, sel_id}, 32'd3);
        run_req(4'd14, 0, 4'd0, blen, nr);
        check("t3_busy_len", blen, 32'd5);
        check("t3_rises", nr, 32'd1);
        check("t3_sel_id", {28'd0, sel_id}, 32'd14);
        check("t3_cur_id", {28'd0, cur_id}, 32'd14);
        check("t3_overrun", {31'd0, overrun}, 32'd0);

        // Second request edge while busy
        run_req(4'd5, 6, 4'd9, blen, nr);
        check("t4_busy_len", blen, 32'd25);
        check("t4_rises", nr, 32'd2);
        check("t4_overrun", {31'd0, overrun}, 32'd1);
        check("t4_cur_id", {28'd0, cur_id}, 32'd5);
        check("t4_sel_id", {28'd0, sel_id}, 32'd5);

        // Reset during the target pulse
        r0      = rise_cnt;
        req_id  = 4'd7;
        req_stb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 2) req_stb = 1'b0;
            if (rise_cnt == r0 + 2) break;
        end
        check("t5_reached_t_hi", rise_cnt - r0, 32'd2);
        step();
        check("t5_in_t_hi", {31'd0, sel_clk}, 32'd1);
        rst = 1'b1;
        step();
        check("t5_sel_clk", {31'd0, sel_clk}, 32'd0);
        check("t5_sel_id", {28'd0, sel_id}, 32'd14);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_cur_valid", {31'd0, cur_valid}, 32'd0);
        check("t5_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step();
        step();
        run_req(4'd7, 0, 4'd0, blen, nr);
        check("t5_busy_len", blen, 32'd25);
        check("t5_rises", nr, 32'd2);
        check("t5_cur_id", {28'd0, cur_id}, 32'd7);
        check("t5_cur_valid_after", {31'd0, cur_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
